magnitude_result_filter: RTL and testbench

Downstream consumer of the magnitude comparator's one-hot result (`a_greater_b`, `a_equal_b`, `a_lower_b`). It qualifies each sampled result, requires a configurable number of consecutive identical valid samples before declaring a new stable relation, and emits a one-cycle change pulse plus a wrapping change counter. It turns a raw, possibly glitchy comparator output into a debounced, registered status for control logic.

---
 rtl/magnitude_result_filter_if.sv | 26 ++
 rtl/magnitude_result_filter.sv | 133 +++++++++++++
 tb/tb_magnitude_result_filter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/magnitude_result_filter_if.sv
// Handshake bundle between a comparator-result source and magnitude_result_filter.
// The master drives the raw one-hot result and clear; the slave returns the debounced status.
interface magnitude_result_filter_if #(
   parameter int unsigned EVT_W = 16
) ();
   logic             in_valid;
   logic             a_greater_b;
   logic             a_equal_b;
   logic             a_lower_b;
   logic             clear;
   logic [1:0]       out_state;
   logic             out_stable;
   logic             change_pulse;
   logic [EVT_W-1:0] event_count;
   logic             error;

   modport master (
      output in_valid, a_greater_b, a_equal_b, a_lower_b, clear,
      input  out_state, out_stable, change_pulse, event_count, error
   );

   modport slave (
      input  in_valid, a_greater_b, a_equal_b, a_lower_b, clear,
      output out_state, out_stable, change_pulse, event_count, error
   );
endinterface

// File: rtl/magnitude_result_filter.sv
// Debounces a one-hot magnitude comparator result into a registered stable relation.
// Define MAG_FILTER_ERR_EN for illegal-code detection; otherwise decode is priority-based.
module magnitude_result_filter #(
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned EVT_W      = 16
) (
   input logic                      clk,
   input logic                      rst_n,
   magnitude_result_filter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

   localparam logic [CNT_W-1:0] RunMax = CNT_W'(STABLE_CNT);

   state_e           state_q, state_d;
   logic [1:0]       cand_q, cand_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [1:0]       out_state_q, out_state_d;
   logic             out_stable_q, out_stable_d;
   logic             pulse_q, pulse_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   logic             err_q, err_d;

   logic [1:0] code;
   logic       smp_en;
   logic       ill_en;
   logic       lock;

   // code 00 means "no usable sample" in both decode flavours
   always_comb begin
      code = 2'b00;
`ifdef MAG_FILTER_ERR_EN
      unique case ({bus.a_greater_b, bus.a_equal_b, bus.a_lower_b})
         3'b100:  code = 2'b11;
         3'b010:  code = 2'b10;
         3'b001:  code = 2'b01;
         default: code = 2'b00;
      endcase
      ill_en = bus.in_valid && (code == 2'b00);
`else
      if (bus.a_greater_b)    code = 2'b11;
      else if (bus.a_equal_b) code = 2'b10;
      else if (bus.a_lower_b) code = 2'b01;
      ill_en = 1'b0;
`endif
      smp_en = bus.in_valid && (code != 2'b00);
   end

   always_comb begin
      cand_d = cand_q;
      run_d  = run_q;
      if (bus.clear) begin
         cand_d = 2'b00;
         run_d  = '0;
      end else if (smp_en) begin
         if (code == cand_q) begin
            run_d = (run_q >= RunMax) ? RunMax : run_q + CNT_W'(1);
         end else begin
            cand_d = code;
            run_d  = CNT_W'(1);
         end
      end else if (ill_en) begin
         run_d = '0;
      end
   end

   assign lock = !bus.clear && smp_en && (run_d == RunMax) && (cand_d != out_state_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear)                           state_d = StIdle;
      else if (lock)                           state_d = StLocked;
      else if (smp_en && (state_q == StIdle))  state_d = StAcquire;
   end

   always_comb begin
      out_state_d  = out_state_q;
      out_stable_d = (state_d == StLocked);
      pulse_d      = 1'b0;
      evt_d        = evt_q;
      err_d        = err_q;
      if (bus.clear) begin
         out_state_d = 2'b00;
         evt_d       = '0;
         err_d       = 1'b0;
      end else begin
         if (lock) begin
            out_state_d = cand_d;
            pulse_d     = 1'b1;
            evt_d       = evt_q + EVT_W'(1);
         end
         if (ill_en) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q       <= 2'b00;
         run_q        <= '0;
         out_state_q  <= 2'b00;
         out_stable_q <= 1'b0;
         pulse_q      <= 1'b0;
         evt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         cand_q       <= cand_d;
         run_q        <= run_d;
         out_state_q  <= out_state_d;
         out_stable_q <= out_stable_d;
         pulse_q      <= pulse_d;
         evt_q        <= evt_d;
         err_q        <= err_d;
      end
   end

   assign bus.out_state    = out_state_q;
   assign bus.out_stable   = out_stable_q;
   assign bus.change_pulse = pulse_q;
   assign bus.event_count  = evt_q;
`ifdef MAG_FILTER_ERR_EN
   assign bus.error        = err_q;
`else
   assign bus.error        = 1'b0;
`endif

endmodule

// File: tb/tb_magnitude_result_filter.sv
// Self-checking bench: directed vector table, corner sequences and random traffic against a
// queue-based model; a second instance with EVT_W=2 exercises event_count wrap.
module tb_magnitude_result_filter;
   localparam int unsigned N = 4;
`ifdef MAG_FILTER_ERR_EN
   localparam bit ErrExp = 1'b1;
`else
   localparam bit ErrExp = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   magnitude_result_filter_if #(.EVT_W(16)) u_if ();
   magnitude_result_filter_if #(.EVT_W(2))  u_if2 ();

   assign u_if2.in_valid    = u_if.in_valid;
   assign u_if2.a_greater_b = u_if.a_greater_b;
   assign u_if2.a_equal_b   = u_if.a_equal_b;
   assign u_if2.a_lower_b   = u_if.a_lower_b;
   assign u_if2.clear       = u_if.clear;

   magnitude_result_filter #(.STABLE_CNT(N), .CNT_W(8), .EVT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   magnitude_result_filter #(.STABLE_CNT(N), .CNT_W(8), .EVT_W(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if2)
   );

   int checks = 0;
   int errors = 0;

   // Model: the relation locks once the last N accepted samples are identical
   logic [1:0]  m_state;
   logic        m_stable, m_pulse, m_err;
   logic [15:0] m_evt;
   logic [1:0]  m_hist[$];

   typedef struct {
      bit          v;
      bit [2:0]    gel;
      logic [1:0]  st;
      bit          pl;
      logic [15:0] evt;
   } vec_t;
   vec_t tbl[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 2'b00;
      m_stable = 1'b0;
      m_pulse  = 1'b0;
      m_err    = 1'b0;
      m_evt    = '0;
      m_hist.delete();
   endtask

   task automatic model_step(bit v, bit [2:0] gel, bit clr);
      logic [1:0] code;
      bit legal, bad, all_eq;
      m_pulse = 1'b0;
      if (clr) begin
         model_reset();
         return;
      end
      if (!v) return;
`ifdef MAG_FILTER_ERR_EN
      legal = ($countones(gel) == 1);
      bad   = !legal;
`else
      legal = (gel != 3'b000);
      bad   = 1'b0;
`endif
      code = gel[2] ? 2'b11 : gel[1] ? 2'b10 : gel[0] ? 2'b01 : 2'b00;
      if (bad) begin
         m_err = 1'b1;
         m_hist.delete();
      end else if (legal) begin
         m_hist.push_back(code);
         if (m_hist.size() > N) void'(m_hist.pop_front());
         if (m_hist.size() == N) begin
            all_eq = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != code) all_eq = 1'b0;
            if (all_eq && code != m_state) begin
               m_state  = code;
               m_pulse  = 1'b1;
               m_evt    = m_evt + 16'd1;
               m_stable = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all(string tag);
      check({tag, ".state"},  32'(u_if.out_state),     32'(m_state));
      check({tag, ".stable"}, 32'(u_if.out_stable),    32'(m_stable));
      check({tag, ".pulse"},  32'(u_if.change_pulse),  32'(m_pulse));
      check({tag, ".evt"},    32'(u_if.event_count),   32'(m_evt));
      check({tag, ".evt2"},   32'(u_if2.event_count),  32'(m_evt[1:0]));
      check({tag, ".error"},  32'(u_if.error),         32'(m_err));
   endtask

   task automatic drive(bit v, bit [2:0] gel, bit clr, string tag);
      u_if.in_valid    = v;
      u_if.a_greater_b = gel[2];
      u_if.a_equal_b   = gel[1];
      u_if.a_lower_b   = gel[0];
      u_if.clear       = clr;
      @(posedge clk);
      #1;
      model_step(v, gel, clr);
      compare_all(tag);
   endtask

   task automatic add(bit v, bit [2:0] gel, logic [1:0] st, bit pl, logic [15:0] evt);
      vec_t x;
      x.v = v; x.gel = gel; x.st = st; x.pl = pl; x.evt = evt;
      tbl.push_back(x);
   endtask

   task automatic do_reset();
      u_if.in_valid = 1'b0;
      u_if.clear    = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      compare_all("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   localparam bit [2:0] G = 3'b100, E = 3'b010, L = 3'b001, Z = 3'b000;

   initial begin
      bit [2:0] gel;
      u_if.in_valid = 1'b0; u_if.a_greater_b = 1'b0; u_if.a_equal_b = 1'b0;
      u_if.a_lower_b = 1'b0; u_if.clear = 1'b0;
      model_reset();
      #12;
      compare_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // directed table: lock G, hold through short L run, lock E, gaps, then wrap sequence
      for (int i = 0; i < 3; i++) add(1, G, 2'b00, 0, 0);
      add(1, G, 2'b11, 1, 1);
      add(0, Z, 2'b11, 0, 1);
      for (int i = 0; i < 3; i++) add(1, L, 2'b11, 0, 1);
      for (int i = 0; i < 3; i++) add(1, E, 2'b11, 0, 1);
      add(1, E, 2'b10, 1, 2);
      add(1, E, 2'b10, 0, 2);
      add(1, G, 2'b10, 0, 2);
      for (int i = 0; i < 5; i++) add(0, G, 2'b10, 0, 2);
      add(1, G, 2'b10, 0, 2);
      add(1, G, 2'b10, 0, 2);
      add(1, G, 2'b11, 1, 3);
      for (int i = 0; i < 3; i++) add(1, L, 2'b11, 0, 3);
      add(1, L, 2'b01, 1, 4);
      for (int i = 0; i < 3; i++) add(1, E, 2'b01, 0, 4);
      add(1, E, 2'b10, 1, 5);
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].gel, 1'b0, "tbl");
         check("tbl.state", 32'(u_if.out_state),    32'(tbl[i].st));
         check("tbl.pulse", 32'(u_if.change_pulse), 32'(tbl[i].pl));
         check("tbl.evt",   32'(u_if.event_count),  32'(tbl[i].evt));
         check("tbl.evt2",  32'(u_if2.event_count), 32'(tbl[i].evt % 4));
      end

      // clear on the 4th matching sample wins over the sample
      for (int i = 0; i < 3; i++) drive(1, G, 0, "clr_pre");
      drive(1, G, 1, "clr_hit");
      check("clr.state",  32'(u_if.out_state),   0);
      check("clr.stable", 32'(u_if.out_stable),  0);
      check("clr.evt",    32'(u_if.event_count), 0);
      for (int i = 0; i < 3; i++) drive(1, G, 0, "clr_post");
      check("clr_post.state", 32'(u_if.out_state), 0);
      drive(1, G, 0, "clr_lock");
      check("clr_lock.state", 32'(u_if.out_state), 3);

      // mid-run reset discards the partial run
      drive(1, L, 0, "rst_pre");
      drive(1, L, 0, "rst_pre");
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, L, 0, "rst_post");
      check("rst_post.state", 32'(u_if.out_state), 0);
      drive(1, L, 0, "rst_lock");
      check("rst_lock.state", 32'(u_if.out_state), 1);

      // multi-hot breaks a run (illegal, or decoded as greater without error detection)
      drive(1, E, 1, "err_clr");
      for (int i = 0; i < 3; i++) drive(1, L, 0, "err_pre");
      drive(1, G | L, 0, "err_hot");
      check("err_seq.error", 32'(u_if.error), 32'(ErrExp));
      for (int i = 0; i < 3; i++) drive(1, L, 0, "err_post");
      check("err_post.state", 32'(u_if.out_state), 0);
      drive(1, L, 0, "err_lock");
      check("err_lock.state", 32'(u_if.out_state), 1);
      drive(1, Z, 0, "zero");

      // random traffic, biased toward repeated one-hot codes so locks occur
      gel = G;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 3) begin
            if ($urandom_range(0, 9) < 8) gel = 3'b001 << $urandom_range(0, 2);
            else gel = 3'($urandom_range(0, 7));
         end
         drive($urandom_range(0, 9) < 8, gel, $urandom_range(0, 199) == 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
